// File: rtl/risc_v_32_i_pkg.sv
// Shared RV32I datapath types: branch-compare operation select and the
// sequential comparator state, plus the helpers that decode them.
package risc_v_32_i_pkg;

  typedef enum logic [2:0] {
    OP_BEQ      = 3'b000,
    OP_BNE      = 3'b001,
    OP_BUNKNOWN = 3'b010,
    OP_BLT      = 3'b100,
    OP_BGE      = 3'b101,
    OP_BLTU     = 3'b110,
    OP_BGEU     = 3'b111
  } comp_select_e;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'b00,
    CMP_SCAN = 2'b01,
    CMP_DONE = 2'b10
  } comp_fsm_e;

  function automatic logic is_scan_op(input comp_select_e op);
    logic r;
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_signed_op(input comp_select_e op);
    logic r;
    case (op)
      OP_BLT, OP_BGE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic map_result(input comp_select_e op, input logic eq, input logic lt);
    logic r;
    case (op)
      OP_BEQ:           r = eq;
      OP_BNE:           r = ~eq;
      OP_BLT, OP_BLTU:  r = lt;
      OP_BGE, OP_BGEU:  r = ~lt;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_comparator_unit_if.sv
// Request/result handshake bundle between the branch-compare issuer and the
// sequential comparator.
interface seq_comparator_unit_if #(parameter int XLEN = 32);
  logic                             flush_i;
  logic                             start_valid_i;
  logic                             start_ready_o;
  logic [XLEN-1:0]                  comp_port_a_i;
  logic [XLEN-1:0]                  comp_port_b_i;
  risc_v_32_i_pkg::comp_select_e    comp_op_sel_i;
  logic                             comp_valid_o;
  logic                             comp_ready_i;
  logic                             comp_o;

  modport master (
    output flush_i, start_valid_i, comp_port_a_i, comp_port_b_i, comp_op_sel_i, comp_ready_i,
    input  start_ready_o, comp_valid_o, comp_o
  );

  modport slave (
    input  flush_i, start_valid_i, comp_port_a_i, comp_port_b_i, comp_op_sel_i, comp_ready_i,
    output start_ready_o, comp_valid_o, comp_o
  );
endinterface

// File: rtl/seq_comparator_unit_chk.sv
// Configuration and protocol checks for seq_comparator_unit.
module seq_comparator_unit_chk #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8
) (
  input logic clk_i,
  input logic rst_i,
  input logic flush_i,
  input logic comp_valid_o,
  input logic comp_ready_i,
  input logic comp_o
);
  if ((SLICE_W < 1) || ((XLEN % SLICE_W) != 0)) begin : g_cfg_err
    $error("seq_comparator_unit: XLEN must be a non-zero multiple of SLICE_W");
  end

  a_result_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (comp_valid_o && !comp_ready_i && !flush_i) |=> (comp_valid_o && $stable(comp_o)));
endmodule

// File: rtl/seq_comparator_unit_comparator_slice.sv
// One SLICE_W-bit compare step; signed_top biases the MSB so a plain unsigned
// compare orders two's-complement values on the most significant slice.
module comparator_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a_slice,
  input  logic [SLICE_W-1:0] b_slice,
  input  logic               signed_top,
  output logic               diff,
  output logic               lt
);
  logic [SLICE_W-1:0] flip_s;
  logic [SLICE_W-1:0] a_adj_s;
  logic [SLICE_W-1:0] b_adj_s;

  // MSB-only bias mask
  always_comb begin
    flip_s = '0;
    flip_s[SLICE_W-1] = signed_top;
  end

  assign a_adj_s = a_slice ^ flip_s;
  assign b_adj_s = b_slice ^ flip_s;
  assign diff    = (a_slice != b_slice);
  assign lt      = (a_adj_s < b_adj_s);
endmodule

// File: rtl/seq_comparator_unit.sv
// Slice-serial RV32I branch comparator: latches operands, scans MSB slice first
// and returns the branch condition over a valid/ready result handshake.
module seq_comparator_unit
  import risc_v_32_i_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SLICE_W    = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic            clk_i,
  input logic            rst_i,
  seq_comparator_unit_if.slave bus
);
  localparam int NSLICES = XLEN / SLICE_W;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICES - 1);

  comp_fsm_e          state_r;
  logic [XLEN-1:0]    a_r;
  logic [XLEN-1:0]    b_r;
  comp_select_e       op_r;
  logic [IDX_W-1:0]   idx_r;
  logic               decided_r;
  logic               eq_r;
  logic               lt_r;
  logic               comp_valid_r;
  logic               comp_r;

  logic [SLICE_W-1:0] a_slice_s;
  logic [SLICE_W-1:0] b_slice_s;
  logic               signed_top_s;
  logic               diff_s;
  logic               lt_s;
  logic               fin_eq_s;
  logic               fin_lt_s;

  assign a_slice_s = a_r[int'(idx_r)*SLICE_W +: SLICE_W];
  assign b_slice_s = b_r[int'(idx_r)*SLICE_W +: SLICE_W];

  comparator_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a_slice    (a_slice_s),
    .b_slice    (b_slice_s),
    .signed_top (signed_top_s),
    .diff       (diff_s),
    .lt         (lt_s)
  );

  // Sign bias selection and the final eq/lt seen on the last scan cycle
  always_comb begin
    signed_top_s = is_signed_op(op_r) && (idx_r == IDX_TOP);
    if (decided_r) begin
      fin_eq_s = eq_r;
      fin_lt_s = lt_r;
    end else if (diff_s) begin
      fin_eq_s = 1'b0;
      fin_lt_s = lt_s;
    end else begin
      fin_eq_s = 1'b1;
      fin_lt_s = 1'b0;
    end
  end

  // Control FSM, operand latches and registered result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= CMP_IDLE;
      a_r          <= '0;
      b_r          <= '0;
      op_r         <= OP_BEQ;
      idx_r        <= IDX_TOP;
      decided_r    <= 1'b0;
      eq_r         <= 1'b0;
      lt_r         <= 1'b0;
      comp_valid_r <= 1'b0;
      comp_r       <= 1'b0;
    end else if (bus.flush_i) begin
      state_r      <= CMP_IDLE;
      comp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        CMP_IDLE: begin
          if (bus.start_valid_i) begin
            a_r       <= bus.comp_port_a_i;
            b_r       <= bus.comp_port_b_i;
            op_r      <= bus.comp_op_sel_i;
            idx_r     <= IDX_TOP;
            decided_r <= 1'b0;
            if (is_scan_op(bus.comp_op_sel_i)) begin
              state_r <= CMP_SCAN;
            end else begin
              // unknown op: result forced low, valid raised one cycle later in CMP_DONE
              state_r <= CMP_DONE;
              comp_r  <= 1'b0;
            end
          end else begin
            state_r <= CMP_IDLE;
          end
        end
        CMP_SCAN: begin
          if (diff_s && !decided_r) begin
            decided_r <= 1'b1;
            eq_r      <= 1'b0;
            lt_r      <= lt_s;
          end else begin
            decided_r <= decided_r;
          end
          if ((EARLY_EXIT && diff_s) || (idx_r == IDX_W'(0))) begin
            if (!decided_r && !diff_s) begin
              eq_r <= 1'b1;
              lt_r <= 1'b0;
            end else begin
              decided_r <= 1'b1;
            end
            state_r      <= CMP_DONE;
            comp_valid_r <= 1'b1;
            comp_r       <= map_result(op_r, fin_eq_s, fin_lt_s);
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        CMP_DONE: begin
          if (!comp_valid_r) begin
            comp_valid_r <= 1'b1;
          end else if (bus.comp_ready_i) begin
            state_r      <= CMP_IDLE;
            comp_valid_r <= 1'b0;
          end else begin
            comp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= CMP_IDLE;
          comp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready_o = (state_r == CMP_IDLE) && !bus.flush_i;
  assign bus.comp_valid_o  = comp_valid_r;
  assign bus.comp_o        = comp_r;

  seq_comparator_unit_chk #(.XLEN(XLEN), .SLICE_W(SLICE_W)) u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (bus.flush_i),
    .comp_valid_o (comp_valid_r),
    .comp_ready_i (bus.comp_ready_i),
    .comp_o       (comp_r)
  );
endmodule

// File: tb/tb_seq_comparator_unit.sv
// Drives three builds in lockstep (default, constant-latency, single-slice) and
// checks results and latency against a whole-operand reference model.
module tb_seq_comparator_unit;
  import risc_v_32_i_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush = 1'b0;
  logic         start_valid = 1'b0;
  logic [31:0]  port_a = 32'h0;
  logic [31:0]  port_b = 32'h0;
  comp_select_e op_sel = OP_BEQ;
  logic         comp_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  seq_comparator_unit_if #(.XLEN(32)) if_ee ();
  seq_comparator_unit_if #(.XLEN(32)) if_ne ();
  seq_comparator_unit_if #(.XLEN(32)) if_sw ();

  assign if_ee.flush_i = flush;       assign if_ne.flush_i = flush;       assign if_sw.flush_i = flush;
  assign if_ee.start_valid_i = start_valid; assign if_ne.start_valid_i = start_valid; assign if_sw.start_valid_i = start_valid;
  assign if_ee.comp_port_a_i = port_a; assign if_ne.comp_port_a_i = port_a; assign if_sw.comp_port_a_i = port_a;
  assign if_ee.comp_port_b_i = port_b; assign if_ne.comp_port_b_i = port_b; assign if_sw.comp_port_b_i = port_b;
  assign if_ee.comp_op_sel_i = op_sel; assign if_ne.comp_op_sel_i = op_sel; assign if_sw.comp_op_sel_i = op_sel;
  assign if_ee.comp_ready_i = comp_ready; assign if_ne.comp_ready_i = comp_ready; assign if_sw.comp_ready_i = comp_ready;

  seq_comparator_unit #(.XLEN(32), .SLICE_W(8),  .EARLY_EXIT(1'b1)) u_ee (.clk_i(clk_i), .rst_i(rst_i), .bus(if_ee));
  seq_comparator_unit #(.XLEN(32), .SLICE_W(8),  .EARLY_EXIT(1'b0)) u_ne (.clk_i(clk_i), .rst_i(rst_i), .bus(if_ne));
  seq_comparator_unit #(.XLEN(32), .SLICE_W(32), .EARLY_EXIT(1'b1)) u_sw (.clk_i(clk_i), .rst_i(rst_i), .bus(if_sw));

  logic [2:0] valid_w, res_w, rdy_w;
  assign valid_w = {if_sw.comp_valid_o,  if_ne.comp_valid_o,  if_ee.comp_valid_o};
  assign res_w   = {if_sw.comp_o,        if_ne.comp_o,        if_ee.comp_o};
  assign rdy_w   = {if_sw.start_ready_o, if_ne.start_ready_o, if_ee.start_ready_o};

  function automatic logic model_res(input comp_select_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return $signed(a) <  $signed(b);
      OP_BGE:  return $signed(a) >= $signed(b);
      OP_BLTU: return a <  b;
      OP_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // unit 0: 4 slices early exit, unit 1: 4 slices full scan, unit 2: one slice
  function automatic int model_k(input int u, input comp_select_e op, input logic [31:0] a, input logic [31:0] b);
    int ns;
    int p;
    logic [31:0] x;
    ns = (u == 2) ? 1 : 4;
    if (!(op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU})) return 1;
    if (u == 1 || a == b) return ns;
    x = a ^ b;
    p = 0;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    return ns - p / (32 / ns);
  endfunction

  task automatic run_op(input comp_select_e op, input logic [31:0] a, input logic [31:0] b, input string name);
    int   lat [3];
    logic got [3];
    logic r_exp;
    int   k_exp;
    r_exp = model_res(op, a, b);
    @(negedge clk_i);
    tests_run++;
    if (rdy_w !== 3'b111) begin
      tests_failed++;
      $display("FAIL %s start_ready got %b want 111", name, rdy_w);
    end
    for (int u = 0; u < 3; u++) begin lat[u] = -1; got[u] = 1'bx; end
    start_valid = 1'b1; op_sel = op; port_a = a; port_b = b;
    @(posedge clk_i); #1;
    start_valid = 1'b0;
    port_a = $urandom; port_b = $urandom; op_sel = comp_select_e'(3'($urandom));
    tests_run++;
    if (valid_w !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s valid_at_accept got %b want 000", name, valid_w);
    end
    for (int cyc = 1; cyc <= 16 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); cyc++) begin
      @(posedge clk_i); #1;
      for (int u = 0; u < 3; u++) begin
        if (lat[u] < 0 && valid_w[u] === 1'b1) begin lat[u] = cyc; got[u] = res_w[u]; end
      end
    end
    for (int u = 0; u < 3; u++) begin
      k_exp = model_k(u, op, a, b);
      tests_run++;
      if (lat[u] !== k_exp) begin
        tests_failed++;
        $display("FAIL %s unit%0d latency got %0d want %0d", name, u, lat[u], k_exp);
      end
      tests_run++;
      if (got[u] !== r_exp) begin
        tests_failed++;
        $display("FAIL %s unit%0d comp_o got %b want %b (a=%h b=%h op=%0d)", name, u, got[u], r_exp, a, b, op);
      end
    end
    @(negedge clk_i); comp_ready = 1'b1;
    @(posedge clk_i); #1; comp_ready = 1'b0;
    tests_run++;
    if (valid_w !== 3'b000 || rdy_w !== 3'b111) begin
      tests_failed++;
      $display("FAIL %s release valid=%b ready=%b want 000/111", name, valid_w, rdy_w);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (valid_w !== 3'b000 || res_w !== 3'b000 || rdy_w !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset valid=%b comp=%b ready=%b want 000/000/111", valid_w, res_w, rdy_w);
    end
  endtask

  task automatic test_directed();
    run_op(OP_BEQ,      32'h1234_5678, 32'h1234_5678, "beq_equal");
    run_op(OP_BNE,      32'h1234_5678, 32'h1234_5678, "bne_equal");
    run_op(OP_BLT,      32'hFFFF_FFFF, 32'h0000_0001, "blt_neg");
    run_op(OP_BLTU,     32'hFFFF_FFFF, 32'h0000_0001, "bltu_big");
    run_op(OP_BGE,      32'h0000_0100, 32'h0000_00FF, "bge_mid");
    run_op(OP_BGEU,     32'h8000_0000, 32'h7FFF_FFFF, "bgeu_top");
    run_op(OP_BLT,      32'h8000_0000, 32'h7FFF_FFFF, "blt_minint");
    run_op(OP_BUNKNOWN, 32'h0000_0000, 32'h0000_0000, "bunknown");
    run_op(comp_select_e'(3'b011), 32'h1, 32'h1, "illegal_op");
  endtask

  task automatic test_backpressure();
    logic done;
    @(negedge clk_i);
    start_valid = 1'b1; op_sel = OP_BEQ; port_a = 32'hCAFE_0001; port_b = 32'hCAFE_0001;
    @(posedge clk_i); #1; start_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(posedge clk_i); #1;
      done = (valid_w === 3'b111);
    end
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL bp_wait valid got %b want 111", valid_w); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      start_valid = 1'b1; op_sel = OP_BNE; port_a = $urandom; port_b = $urandom;
      @(posedge clk_i); #1;
      tests_run++;
      if (valid_w !== 3'b111 || res_w !== 3'b111 || rdy_w !== 3'b000) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d valid=%b comp=%b ready=%b want 111/111/000", c, valid_w, res_w, rdy_w);
      end
    end
    @(negedge clk_i); start_valid = 1'b0; comp_ready = 1'b1;
    @(posedge clk_i); #1; comp_ready = 1'b0;
    tests_run++;
    if (valid_w !== 3'b000 || rdy_w !== 3'b111) begin
      tests_failed++;
      $display("FAIL bp_release valid=%b ready=%b want 000/111", valid_w, rdy_w);
    end
    done = 1'b0;
    for (int c = 0; c < 6; c++) begin @(posedge clk_i); #1; if (valid_w !== 3'b000) done = 1'b1; end
    tests_run++;
    if (done) begin tests_failed++; $display("FAIL bp_ignored_start spurious valid got 1 want 0"); end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk_i);
    start_valid = 1'b1; op_sel = OP_BEQ; port_a = 32'h5555_AAAA; port_b = 32'h5555_AAAA;
    @(posedge clk_i); #1; start_valid = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i); flush = 1'b1; #1;
    tests_run++;
    if (rdy_w !== 3'b000) begin tests_failed++; $display("FAIL flush_ready got %b want 000", rdy_w); end
    @(posedge clk_i); #1;
    tests_run++;
    if (valid_w !== 3'b000) begin tests_failed++; $display("FAIL flush_valid got %b want 000", valid_w); end
    @(negedge clk_i); flush = 1'b0; #1;
    tests_run++;
    if (rdy_w !== 3'b111) begin tests_failed++; $display("FAIL flush_idle ready got %b want 111", rdy_w); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin @(posedge clk_i); #1; if (valid_w !== 3'b000) seen = 1'b1; end
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL flush_no_pulse valid got 1 want 0"); end
  endtask

  task automatic test_reset_mid_scan();
    logic seen;
    @(negedge clk_i);
    start_valid = 1'b1; op_sel = OP_BEQ; port_a = 32'h0F0F_0F0F; port_b = 32'h0F0F_0F0F;
    @(posedge clk_i); #1; start_valid = 1'b0;
    @(posedge clk_i); #1;
    tests_run++;
    if (valid_w !== 3'b100 || res_w[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset valid=%b comp2=%b want 100/1", valid_w, res_w[2]);
    end
    #2 rst_i = 1'b1; #1;
    tests_run++;
    if (valid_w !== 3'b000 || res_w !== 3'b000) begin
      tests_failed++;
      $display("FAIL async_reset valid=%b comp=%b want 000/000", valid_w, res_w);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin @(posedge clk_i); #1; if (valid_w !== 3'b000) seen = 1'b1; end
    tests_run++;
    if (seen || rdy_w !== 3'b111) begin
      tests_failed++;
      $display("FAIL post_reset stale=%b ready=%b want 0/111", seen, rdy_w);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    comp_select_e op;
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = {a[31:8], 8'($urandom)};
      endcase
      op = comp_select_e'(3'($urandom));
      run_op(op, a, b, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
